// File: rtl/spi_pkg.sv
// Shared definitions for the SPI monarch: FSM state encoding and the
// slave-select index width helper.
package spi_pkg;

  // Frame sequencing states of the monarch
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FRT_PRCH = 2'd1,
    TRANS    = 2'd2,
    BCK_PRCH = 2'd3
  } spi_state_t;

  // Width of the slave-select index: clog2 of the select count, never below 1
  function automatic int sel_w(input int num_ss);
    int w_v;
    w_v = $clog2(num_ss);
    if (w_v < 1) begin
      w_v = 1;
    end else begin
      w_v = w_v;
    end
    return w_v;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: a half-period counter that toggles SCLK every HALF_PER
// clk cycles and flags each rising and falling edge with a one-cycle strobe.
// The strobes are registered together with SCLK, so a strobe is high in
// exactly the first cycle that the new SCLK level is visible.
module spi_sclk_gen #(
  parameter int HALF_PER = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,        // restart a full high phase
  input  logic force_high,  // hold SCLK high, counter parked at zero
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic ph_last      // current half-period ends with this cycle
);

  localparam int CNT_W = $clog2(HALF_PER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             sclk_r;
  logic             rise_r;
  logic             fall_r;

  assign ph_last = (cnt_r == CNT_LAST);

  // Half-period counter, SCLK level and edge strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      sclk_r <= 1'b1;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else if (load || force_high) begin
      cnt_r  <= '0;
      sclk_r <= 1'b1;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else if (ph_last) begin
      cnt_r  <= '0;
      sclk_r <= ~sclk_r;
      rise_r <= ~sclk_r;
      fall_r <= sclk_r;
    end else begin
      cnt_r  <= cnt_r + CNT_ONE;
      sclk_r <= sclk_r;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end
  end

  assign sclk = sclk_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/spi_mnrch_gen.sv
// SPI monarch: shifts a DATA_W-bit frame MSB-first on MOSI while capturing
// MISO on each SCLK rising edge, driving one of NUM_SS active-low selects.
// A frame may leave its select low (hold) so a burst of frames to the same
// slave keeps it selected until a frame completes with hold cleared.
module spi_mnrch_gen
  import spi_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int HALF_PER = 16,
  parameter  int NUM_SS   = 1,
  localparam int SEL_W    = sel_w(NUM_SS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] wrt_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              hold,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data
);

  localparam int BIT_W = $clog2(DATA_W);
  // Shift index at which the last in-frame fall moves us to the back porch
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 2);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [SEL_W:0]   NUM_SS_L = (SEL_W + 1)'(NUM_SS);

  spi_state_t        state_r;
  logic [DATA_W-1:0] shft_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic              miso_smpl_r;
  logic [NUM_SS-1:0] ss_n_r;
  logic              hold_r;
  logic              done_r;
  logic              busy_r;

  logic              sclk_s;
  logic              rise_s;
  logic              fall_s;
  logic              ph_last_s;
  logic              load_s;
  logic              force_high_s;
  logic              accept_s;
  logic              sel_ok_s;
  logic [NUM_SS-1:0] ss_sel_n_s;

  spi_sclk_gen #(
    .HALF_PER (HALF_PER)
  ) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .force_high (force_high_s),
    .sclk       (sclk_s),
    .rise       (rise_s),
    .fall       (fall_s),
    .ph_last    (ph_last_s)
  );

  // Start acceptance and SCLK control; in the back porch the would-be
  // falling edge after the final high phase is suppressed by forcing high
  always_comb begin
    sel_ok_s     = ({1'b0, ss_sel} < NUM_SS_L);
    accept_s     = 1'b0;
    load_s       = 1'b0;
    force_high_s = 1'b0;
    case (state_r)
      IDLE: begin
        force_high_s = 1'b1;
        if (wrt && sel_ok_s) begin
          accept_s = 1'b1;
          load_s   = 1'b1;
        end else begin
          accept_s = 1'b0;
          load_s   = 1'b0;
        end
      end
      BCK_PRCH: begin
        force_high_s = sclk_s & ph_last_s;
      end
      default: begin
        force_high_s = 1'b0;
      end
    endcase
  end

  // Active-low one-hot decode of the requested slave index
  always_comb begin
    ss_sel_n_s = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SEL_W'(i)) begin
        ss_sel_n_s[i] = 1'b0;
      end else begin
        ss_sel_n_s[i] = 1'b1;
      end
    end
  end

  // Frame FSM with shift register, bit counter and select/done/hold flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      shft_r      <= '0;
      bit_cnt_r   <= '0;
      miso_smpl_r <= 1'b0;
      ss_n_r      <= '1;
      hold_r      <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shft_r    <= wrt_data;
            hold_r    <= hold;
            ss_n_r    <= ss_sel_n_s;  // a previously held select rises here
            done_r    <= 1'b0;
            busy_r    <= 1'b1;
            bit_cnt_r <= '0;
            state_r   <= FRT_PRCH;
          end else begin
            state_r   <= IDLE;
          end
        end
        FRT_PRCH: begin
          // The first fall only opens the frame; nothing sampled yet
          if (fall_s) begin
            state_r <= TRANS;
          end else begin
            state_r <= FRT_PRCH;
          end
        end
        TRANS: begin
          if (rise_s) begin
            miso_smpl_r <= MISO;
          end else begin
            miso_smpl_r <= miso_smpl_r;
          end
          if (fall_s) begin
            shft_r    <= {shft_r[DATA_W-2:0], miso_smpl_r};
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
            if (bit_cnt_r == BIT_LAST) begin
              state_r <= BCK_PRCH;
            end else begin
              state_r <= TRANS;
            end
          end else begin
            state_r <= TRANS;
          end
        end
        BCK_PRCH: begin
          if (rise_s) begin
            miso_smpl_r <= MISO;
          end else begin
            miso_smpl_r <= miso_smpl_r;
          end
          // End of the final high phase: last shift, frame complete
          if (force_high_s) begin
            shft_r  <= {shft_r[DATA_W-2:0], miso_smpl_r};
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
            if (!hold_r) begin
              ss_n_r <= '1;
            end else begin
              ss_n_r <= ss_n_r;
            end
          end else begin
            state_r <= BCK_PRCH;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign SS_n    = ss_n_r;
  assign SCLK    = sclk_s;
  assign MOSI    = shft_r[DATA_W-1];
  assign done    = done_r;
  assign busy    = busy_r;
  assign rd_data = shft_r;

endmodule

// File: tb/tb_spi_mnrch_gen.sv
// Bench for spi_mnrch_gen: instance A (16-bit, HALF_PER=16, one select,
// loopback slave) and instance B (8-bit, HALF_PER=4, four selects, pattern
// slave). Instance B is checked every cycle against a timing model derived
// from the frame arithmetic; directed literal checks pin both instances.
module tb_spi_mnrch_gen;

  localparam int B_DW   = 8;
  localparam int B_HP   = 4;
  localparam int B_NS   = 4;
  localparam int B_FLEN = B_HP * (2 * B_DW + 1);
  localparam int A_FLEN = 16 * (2 * 16 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- instance A ----------------
  logic        a_rst, a_wrt, a_hold, a_miso;
  logic [15:0] a_data, a_rd;
  logic [0:0]  a_sel, a_ssn;
  logic        a_sclk, a_mosi, a_done, a_busy;
  logic [15:0] a_cap = 16'h0000;

  assign a_miso = a_mosi;

  spi_mnrch_gen #(.DATA_W(16), .HALF_PER(16), .NUM_SS(1)) dut_a (
    .clk(clk), .rst(a_rst), .wrt(a_wrt), .wrt_data(a_data), .ss_sel(a_sel),
    .hold(a_hold), .MISO(a_miso), .SS_n(a_ssn), .SCLK(a_sclk), .MOSI(a_mosi),
    .done(a_done), .busy(a_busy), .rd_data(a_rd)
  );

  // MOSI as seen by the slave at each SCLK rise
  always @(posedge a_sclk) a_cap <= {a_cap[14:0], a_mosi};

  // ---------------- instance B ----------------
  logic       b_rst, b_wrt, b_hold, b_miso;
  logic [7:0] b_data, b_rd;
  logic [1:0] b_sel;
  logic [3:0] b_ssn;
  logic       b_sclk, b_mosi, b_done, b_busy;

  spi_mnrch_gen #(.DATA_W(B_DW), .HALF_PER(B_HP), .NUM_SS(B_NS)) dut_b (
    .clk(clk), .rst(b_rst), .wrt(b_wrt), .wrt_data(b_data), .ss_sel(b_sel),
    .hold(b_hold), .MISO(b_miso), .SS_n(b_ssn), .SCLK(b_sclk), .MOSI(b_mosi),
    .done(b_done), .busy(b_busy), .rd_data(b_rd)
  );

  // Slave: presents pattern bit (8 - falls seen) so rise k carries bit 7-k
  int         b_nfall = 0;
  int         fbase   = 0;
  int         fk;
  logic [7:0] slv_pat = 8'h00;
  always @(negedge b_sclk) b_nfall <= b_nfall + 1;
  always_comb begin
    fk = b_nfall - fbase;
    if (fk >= 1 && fk <= 8) b_miso = slv_pat[8 - fk];
    else                    b_miso = 1'b0;
  end

  // ---------------- model of instance B ----------------
  bit         m_en = 1'b0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_hold = 1'b0;
  int         m_t = 0;
  logic [7:0] m_data = 8'h00, m_rd = 8'h00;
  logic [3:0] m_ssn = 4'hF;
  bit         mon_on = 1'b0, ss1_rose = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    int   d, j;
    logic e_sclk;
    if (!m_en) return;
    if (m_busy) begin
      d = cyc - m_t - 1;
      if (d < B_HP) e_sclk = 1'b1;
      else          e_sclk = (((d - B_HP) / B_HP) % 2) == 1;
      j = 0;
      for (int k = 1; k < B_DW; k++) if (d >= B_HP + 2 * k * B_HP + 1) j++;
      chk("b_sclk", b_sclk, e_sclk);
      chk("b_mosi", b_mosi, m_data[B_DW - 1 - j]);
      chk("b_busy", b_busy, 1'b1);
      chk("b_done", b_done, 1'b0);
      chk("b_ssn", b_ssn, m_ssn);
    end else begin
      chk("b_sclk_idle", b_sclk, 1'b1);
      chk("b_busy_idle", b_busy, 1'b0);
      chk("b_done_idle", b_done, m_done);
      chk("b_ssn_idle", b_ssn, m_ssn);
      if (m_done) chk("b_rd", b_rd, m_rd);
    end
    if (mon_on && b_ssn[1] === 1'b1) ss1_rose = 1'b1;
    // advance the model to the next cycle
    if (b_rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_ssn = 4'hF;
    end else if (m_busy) begin
      if (cyc + 1 == m_t + 1 + B_FLEN) begin
        m_busy = 1'b0; m_done = 1'b1;
        if (!m_hold) m_ssn = 4'hF;
      end
    end else if (b_wrt && int'(b_sel) < B_NS) begin
      m_t = cyc; m_busy = 1'b1; m_done = 1'b0; m_hold = b_hold;
      m_data = b_data; m_rd = slv_pat; m_ssn = ~(4'b0001 << b_sel);
    end
  endtask

  task automatic b_start(input logic [7:0] d, input logic [1:0] s, input logic h,
                         input logic [7:0] p, output int t);
    b_data = d; b_sel = s; b_hold = h; slv_pat = p; fbase = b_nfall;
    b_wrt = 1'b1; t = cyc;
    @(posedge clk); #1;
    b_wrt = 1'b0;
  endtask

  task automatic b_wait_done(input string nm, output int t);
    bit seen;
    seen = 1'b0; t = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      if (b_done === 1'b1) begin seen = 1'b1; t = cyc; end
    end
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL %s: done never seen within 300 cycles", nm);
    end
  endtask

  initial begin : main
    int t0, t1, bit_seen;
    fork
      forever begin @(negedge clk); model_step(); end
    join_none

    a_rst = 1'b1; a_wrt = 1'b0; a_data = 16'h0000; a_sel = 1'b0; a_hold = 1'b0;
    b_rst = 1'b1; b_wrt = 1'b0; b_data = 8'h00; b_sel = 2'd0; b_hold = 1'b0;
    @(posedge clk); #1;
    m_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_ssn", a_ssn, 1'b1);
    chk("a_rst_sclk", a_sclk, 1'b1);
    chk("a_rst_done", a_done, 1'b0);
    chk("a_rst_busy", a_busy, 1'b0);
    chk("b_rst_ssn", b_ssn, 4'hF);
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;

    // A: out-of-range select ignored in IDLE
    a_sel = 1'b1; a_wrt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("a_badsel_busy", a_busy, 1'b0);
      chk("a_badsel_ssn", a_ssn, 1'b1);
      chk("a_badsel_done", a_done, 1'b0);
    end
    a_wrt = 1'b0;

    // A: 16-bit loopback frame
    a_sel = 1'b0; a_data = 16'hA5C3; a_wrt = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    a_wrt = 1'b0;
    chk("a_start_ssn", a_ssn, 1'b0);
    chk("a_start_busy", a_busy, 1'b1);
    chk("a_start_mosi", a_mosi, 1'b1);
    bit_seen = 0; t1 = -1;
    for (int i = 0; i < 700 && bit_seen == 0; i++) begin
      @(posedge clk); #1;
      if (a_done === 1'b1) begin bit_seen = 1; t1 = cyc; end
    end
    if (bit_seen == 0) begin
      n_chk++; n_err++;
      $display("FAIL a_done: done never seen within 700 cycles");
    end
    chk("a_done_lat", t1 - t0, 529);
    chk("a_flen_model", A_FLEN + 1, 529);
    chk("a_rd", a_rd, 16'hA5C3);
    chk("a_mosi_seq", a_cap, 16'hA5C3);
    chk("a_end_ssn", a_ssn, 1'b1);
    chk("a_end_busy", a_busy, 1'b0);

    // B: select 2, slave returns 3C, stray wrt mid-frame ignored
    b_start(8'h5A, 2'd2, 1'b0, 8'h3C, t0);
    repeat (10) @(posedge clk);
    #1;
    chk("b1_ssn_lit", b_ssn, 4'b1011);
    b_sel = 2'd0; b_data = 8'hFF; b_hold = 1'b1; b_wrt = 1'b1;
    @(posedge clk); #1;
    b_wrt = 1'b0; b_hold = 1'b0;
    chk("b1_ssn_after_stray", b_ssn, 4'b1011);
    b_wait_done("b1_done", t1);
    chk("b1_done_lat", t1 - t0, 69);
    chk("b1_rd_lit", b_rd, 8'h3C);
    chk("b1_falls", b_nfall - fbase, 8);
    chk("b1_ssn_end", b_ssn, 4'hF);

    // B: held frame to select 1, then a releasing frame to select 1
    repeat (3) @(posedge clk);
    #1;
    b_start(8'hC3, 2'd1, 1'b1, 8'h81, t0);
    mon_on = 1'b1;
    b_wait_done("b2_done", t1);
    chk("b2_rd_lit", b_rd, 8'h81);
    chk("b2_ssn_held", b_ssn, 4'b1101);
    b_start(8'h18, 2'd1, 1'b0, 8'h7E, t0);
    b_wait_done("b3_done", t1);
    mon_on = 1'b0;
    chk("b3_ss1_continuous", ss1_rose, 1'b0);
    chk("b3_done_lat", t1 - t0, 69);
    chk("b3_rd_lit", b_rd, 8'h7E);
    chk("b3_ssn_end", b_ssn, 4'hF);

    // B: reset at the 7th SCLK fall, then a fresh frame
    repeat (2) @(posedge clk);
    #1;
    b_start(8'h96, 2'd3, 1'b0, 8'h55, t0);
    bit_seen = 0;
    for (int i = 0; i < 200 && bit_seen == 0; i++) begin
      if (b_nfall - fbase >= 7) bit_seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("b4_reached_fall7", b_nfall - fbase, 7);
    b_rst = 1'b1;
    @(posedge clk); #1;
    chk("b4_rst_ssn", b_ssn, 4'hF);
    chk("b4_rst_sclk", b_sclk, 1'b1);
    chk("b4_rst_done", b_done, 1'b0);
    chk("b4_rst_busy", b_busy, 1'b0);
    b_rst = 1'b0;
    @(posedge clk); #1;
    b_start(8'h0F, 2'd0, 1'b0, 8'hA5, t0);
    b_wait_done("b5_done", t1);
    chk("b5_done_lat", t1 - t0, 69);
    chk("b5_rd_lit", b_rd, 8'hA5);
    chk("b5_ssn_end", b_ssn, 4'hF);
    repeat (4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
